// File: rtl/direction_encoder.sv
// Direction button encoder: sync + debounce four buttons, encode each new press as a 2-bit select code
// on a valid/ready handshake. Optional auto-repeat while held is enabled with `define DIR_ENC_REPEAT_EN.
module direction_encoder #(
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = 5
`ifdef DIR_ENC_REPEAT_EN
  ,
  parameter int RPT_CYCLES = 1000,
  parameter int RPT_W      = 10
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic up,
  input  logic right,
  input  logic down,
  input  logic left,
  input  logic code_ready,
  output logic code_valid,
  output logic select1,
  output logic select0,
  output logic multi
);

  typedef enum logic [1:0] {IDLE, VALID, RELEASE} state_t;

  state_t          state;
  logic [3:0]      raw;
  logic [3:0]      sync_p0;
  logic [3:0]      sync_p1;
  logic [3:0]      deb;
  logic [3:0]      deb_q;
  logic [3:0]      press;
  logic [DB_W-1:0] db_cnt [4];
`ifdef DIR_ENC_REPEAT_EN
  logic [RPT_W-1:0] rpt_cnt;
`endif

  // Bit index doubles as the select code: up=0, right=1, down=2, left=3.
  assign raw   = {left, down, right, up};
  assign press = deb & ~deb_q;

  function automatic logic [1:0] encode(input logic [3:0] p);
    if (p[0])      return 2'd0;
    else if (p[1]) return 2'd1;
    else if (p[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic more_than_one(input logic [3:0] d);
    return |(d & (d - 4'd1));
  endfunction

  // Stage p0/p1: two-flop synchroniser, then per-line debounce and press edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb     <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      deb_q   <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          deb[i]    <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Handshake FSM: outputs are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      code_valid <= 1'b0;
      select1    <= 1'b0;
      select0    <= 1'b0;
      multi      <= 1'b0;
`ifdef DIR_ENC_REPEAT_EN
      rpt_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|press) begin
            {select1, select0} <= encode(press);
            multi              <= more_than_one(deb);
            code_valid         <= 1'b1;
            state              <= VALID;
          end
        end
        VALID: begin
`ifdef DIR_ENC_REPEAT_EN
          rpt_cnt <= '0;
`endif
          if (code_ready) begin
            code_valid <= 1'b0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          if (deb == 4'd0) begin
            state <= IDLE;
          end
`ifdef DIR_ENC_REPEAT_EN
          // Only the originally captured button held on its own keeps the repeat timer running.
          else if (deb == (4'b0001 << {select1, select0})) begin
            if (rpt_cnt == RPT_W'(RPT_CYCLES - 1)) begin
              rpt_cnt    <= '0;
              multi      <= 1'b0;
              code_valid <= 1'b1;
              state      <= VALID;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end else begin
            rpt_cnt <= '0;
          end
`endif
        end
        default: begin
          code_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_direction_encoder.sv
// Bench for direction_encoder: directed scenarios plus randomized button traffic checked every cycle
// against a behavioural model built from press/debounce/handshake rules.
module tb_direction_encoder;

  localparam int DB = 4;
`ifdef DIR_ENC_REPEAT_EN
  localparam int RPT = 8;
`endif
  localparam int S_IDLE = 0, S_VALID = 1, S_RELEASE = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic up = 1'b0, right = 1'b0, down = 1'b0, left = 1'b0, code_ready = 1'b0;
  logic code_valid, select1, select0, multi;

  int checks = 0, errors = 0, nvalid = 0;

  int         m_state;
  logic [3:0] m_deb, m_deb_prev;
  logic [1:0] m_code;
  logic       m_multi;
  int         m_rpt;
  logic [3:0] rq[$];

  direction_encoder #(
    .DB_CYCLES(DB),
    .DB_W(5)
`ifdef DIR_ENC_REPEAT_EN
    ,
    .RPT_CYCLES(RPT),
    .RPT_W(10)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .up(up), .right(right), .down(down), .left(left),
    .code_ready(code_ready), .code_valid(code_valid), .select1(select1), .select0(select0),
    .multi(multi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_deb = '0; m_deb_prev = '0; m_code = '0; m_multi = 1'b0; m_rpt = 0;
    rq.delete();
    for (int i = 0; i < DB + 2; i++) rq.push_back(4'd0);
  endtask

  // One clock edge of the reference: r/rdy are the inputs present at that edge.
  task automatic model_edge(input logic [3:0] r, input logic rdy);
    logic [3:0] od, press;
    logic       found, flip;
    od    = m_deb;
    press = od & ~m_deb_prev;
    case (m_state)
      S_IDLE: if (press != 4'd0) begin
        found = 1'b0;
        for (int i = 0; i < 4; i++) if (press[i] && !found) begin m_code = 2'(i); found = 1'b1; end
        m_multi = ($countones(od) > 1);
        m_state = S_VALID;
      end
      S_VALID: begin
        m_rpt = 0;
        if (rdy) m_state = S_RELEASE;
      end
      default: begin
        if (od == 4'd0) m_state = S_IDLE;
`ifdef DIR_ENC_REPEAT_EN
        else if (od == (4'b0001 << m_code)) begin
          if (m_rpt == RPT - 1) begin m_state = S_VALID; m_multi = 1'b0; m_rpt = 0; end
          else m_rpt++;
        end else m_rpt = 0;
`endif
      end
    endcase
    m_deb_prev = od;
    rq.push_back(r);
    // A line's debounced level flips once its synced copy (raw delayed two edges)
    // has disagreed with it for the last DB edges.
    for (int i = 0; i < 4; i++) begin
      flip = 1'b1;
      for (int k = 0; k < DB; k++) if (rq[rq.size() - 3 - k][i] == od[i]) flip = 1'b0;
      if (flip) m_deb[i] = ~od[i];
    end
    if (rq.size() > 40) void'(rq.pop_front());
  endtask

  task automatic step(input logic [3:0] r, input logic rdy);
    {left, down, right, up} = r;
    code_ready = rdy;
    @(posedge clk);
    #1;
    model_edge(r, rdy);
    if (code_valid === 1'b1) nvalid++;
    check("code_valid", code_valid, (m_state == S_VALID));
    if (m_state == S_VALID) begin
      check("select", {select1, select0}, m_code);
      check("multi", multi, m_multi);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 1'b1);
  endtask

  initial begin
    int n0, first, hold;
    logic [1:0] fsel;
    logic fmulti;
    logic [3:0] rr;
    logic rdy;

    model_reset();
    #12;
    check("rst_valid", code_valid, 1'b0);
    check("rst_sel1", select1, 1'b0);
    check("rst_sel0", select0, 1'b0);
    check("rst_multi", multi, 1'b0);
    rst_n = 1'b1;

    // 1: short up glitch rejected, then right press with latency check
    n0 = nvalid;
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b1);
    idle(10);
    check("t1_glitch_count", nvalid - n0, 0);
    first = -1; fsel = '0; fmulti = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(4'b0010, 1'b1);
      if (code_valid === 1'b1 && first < 0) begin first = k; fsel = {select1, select0}; fmulti = multi; end
    end
    check("t1_latency", first, 7);
    check("t1_sel", fsel, 2'b01);
    check("t1_multi", fmulti, 1'b0);
    idle(12);

    // 2: down+left together, consumer stalls for 20 cycles
    n0 = nvalid;
    for (int i = 0; i < 26; i++) step(4'b1100, 1'b0);
    check("t2_hold_count", nvalid - n0, 20);
    check("t2_sel", {select1, select0}, 2'b10);
    check("t2_multi", multi, 1'b1);
    step(4'b1100, 1'b1);
    check("t2_after_xfer", code_valid, 1'b0);
    idle(12);

    // 3: second button while first still held is ignored until full release
    for (int i = 0; i < 8; i++) step(4'b1000, 1'b1);
    n0 = nvalid;
    for (int i = 0; i < 15; i++) step(4'b1001, 1'b1);
    idle(10);
    check("t3_no_second", nvalid - n0, 0);
    n0 = nvalid;
    fsel = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step(4'b0001, 1'b1);
      if (code_valid === 1'b1) fsel = {select1, select0};
    end
    check("t3_up_count", nvalid - n0, 1);
    check("t3_up_sel", fsel, 2'b00);
    idle(12);

    // 4: reset while a code is pending
    for (int i = 0; i < 10; i++) step(4'b0100, 1'b0);
    {left, down, right, up} = 4'd0;
    #2 rst_n = 1'b0;
    #1;
    check("t4_valid", code_valid, 1'b0);
    check("t4_sel", {select1, select0}, 2'b00);
    check("t4_multi", multi, 1'b0);
    model_reset();
    #2 rst_n = 1'b1;
    n0 = nvalid;
    for (int i = 0; i < 15; i++) step(4'd0, 1'b0);
    check("t4_no_code", nvalid - n0, 0);
    n0 = nvalid;
    for (int i = 0; i < 8; i++) step(4'b0100, 1'b1);
    check("t4_new_press", nvalid - n0, 1);
    idle(12);

    // 5: bouncing right button
    n0 = nvalid;
    step(4'b0010, 1'b1); step(4'b0000, 1'b1); step(4'b0010, 1'b1);
    step(4'b0010, 1'b1); step(4'b0000, 1'b1);
    for (int i = 0; i < 8; i++) step(4'b0010, 1'b1);
    idle(12);
    check("t5_bounce_count", nvalid - n0, 1);

    // 6: long hold of down
    n0 = nvalid;
    for (int i = 0; i < 40; i++) step(4'b0100, 1'b1);
    idle(12);
`ifdef DIR_ENC_REPEAT_EN
    check("t6_repeat_count", nvalid - n0, 5);
`else
    check("t6_single_count", nvalid - n0, 1);
`endif

    // Randomized traffic against the model
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 2) == 0) rr = 4'(1 << $urandom_range(0, 3));
      else rr = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 14);
      for (int i = 0; i < hold; i++) begin
        rdy = ($urandom_range(0, 3) != 0);
        step(rr, rdy);
      end
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
